gf2m_mul571_arbiter: RTL

- Shares one GF(2^571) multiplier instance (gf2m_mult571, field polynomial x^571+x^10+x^5+x^2+1) among NREQ requesters, e.g. the inversion unit and the point add/double sequencer.
- Arbitration is round-robin with a valid/ready request handshake.
- A latency-matched tag pipeline routes each product back to the requester that issued it.
- Supports either a fully pipelined multiplier (one issue per cycle) or a blocking mode with one operation outstanding.

---
 rtl/gf2m_mul571_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gf2m_mul571_arbiter.sv
// Round-robin sharing of one GF(2^571) multiplier among NREQ requesters with tag-routed results.
// Accept-to-rsp_valid latency MUL_LAT+2; no response backpressure, request side is valid/ready.

module gf2m_mult571 #(
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic [570:0] a,
  input  logic [570:0] b,
  output logic [570:0] c
);
  localparam logic [570:0] POLY_LOW = 571'h425;  // x^10 + x^5 + x^2 + 1

  function automatic logic [570:0] gf_mul(input logic [570:0] x_in, input logic [570:0] y);
    logic [570:0] acc;
    logic [570:0] x;
    acc = '0;
    x   = x_in;
    for (int i = 0; i < 571; i++) begin
      if (y[i]) acc = acc ^ x;
      x = {x[569:0], 1'b0} ^ (x[570] ? POLY_LOW : '0);
    end
    return acc;
  endfunction

  logic [570:0] pipe [LAT];

  always_ff @(posedge clk) begin
    pipe[0] <= gf_mul(a, b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign c = pipe[LAT-1];
endmodule

module gf2m_mul571_arbiter #(
  parameter int NREQ      = 2,
  parameter int MUL_LAT   = 3,
  parameter int PIPELINED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*571-1:0] req_a,
  input  logic [NREQ*571-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [570:0]        rsp_data,
  output logic                busy
);
  localparam int W   = 571;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MUL_LAT + 2);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            issue_ok;
  logic            in_wait;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            accept;

  logic [W-1:0]    mul_a, mul_b, mul_c;
  logic [MUL_LAT:0] tag_vld;
  logic [IDW-1:0]  tag_id [MUL_LAT+1];
  logic [NREQ-1:0] rsp_onehot;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    gnt     = '0;
    gnt_id  = ptr;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

  assign req_ready = issue_ok ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Operand registers hold between issues; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_a <= req_a[gnt_id*W +: W];
      mul_b <= req_b[gnt_id*W +: W];
    end
  end

  gf2m_mult571 #(.LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .c   (mul_c)
  );

  always_ff @(posedge clk) begin
    if (rst) tag_vld <= '0;
    else     tag_vld <= {tag_vld[MUL_LAT-1:0], accept};
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int i = 1; i <= MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  always_comb begin
    rsp_onehot                  = '0;
    rsp_onehot[tag_id[MUL_LAT]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_vld[MUL_LAT]) begin
        rsp_valid <= rsp_onehot;
        rsp_data  <= mul_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Leaving WAIT as the count hits 0 lets a new grant coincide with rsp_valid.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept && PIPELINED == 0) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(MUL_LAT + 1);
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_wait  = (state == S_WAIT);
    issue_ok = !rst && (PIPELINED != 0 || state == S_IDLE);
  end

  assign busy = ((PIPELINED != 0) ? (|tag_vld) : in_wait) | (|rsp_valid);
endmodule
